arbitro_rr_4a1: RTL and testbench

//  4:1 round-robin arbiter: drains four input FIFOs into one downstream FIFO, WORD_SIZE-bit words.

---
 rtl/arbitro_rr_4a1_pkg.sv | 18 +
 rtl/arbitro_rr_4a1_if.sv | 27 ++
 rtl/arbitro_rr_4a1_sel.sv | 25 ++
 rtl/arbitro_rr_4a1.sv | 104 ++++++++++
 tb/tb_arbitro_rr_4a1.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr_4a1_pkg.sv
// Shared types and constants for the 4:1 round-robin arbiter.
// Holds the FSM encoding, the source count and the word-counter width.
package arbitro_rr_4a1_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam int NUM_FIFOS = 4;
   localparam int CUENTA_W  = 5;

   function automatic logic [NUM_FIFOS-1:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/arbitro_rr_4a1_if.sv
// FIFO-side bundle of the arbiter: four show-ahead sources in, one downstream FIFO out.
// The arbiter uses the slave modport; whoever models the FIFOs uses master.
interface arbitro_rr_4a1_if
   import arbitro_rr_4a1_pkg::*;
#(
   parameter int WORD_SIZE = 12
);
   logic [NUM_FIFOS*WORD_SIZE-1:0] data_in;
   logic [NUM_FIFOS-1:0]           fifos_empty;
   logic                           fifo_almost_full;
   logic [NUM_FIFOS-1:0]           pop;
   logic                           push;
   logic [WORD_SIZE-1:0]           data_out;
   logic [1:0]                     grant;
   logic                           idle;
   logic [CUENTA_W-1:0]            cuenta;

   modport slave (
      input  data_in, fifos_empty, fifo_almost_full,
      output pop, push, data_out, grant, idle, cuenta
   );

   modport master (
      output data_in, fifos_empty, fifo_almost_full,
      input  pop, push, data_out, grant, idle, cuenta
   );
endinterface

// File: rtl/arbitro_rr_4a1_sel.sv
// Rotate-priority selector: first eligible source scanning upward from rr_ptr, modulo 4.
module arbitro_rr_4a1_sel
   import arbitro_rr_4a1_pkg::*;
(
   input  logic [NUM_FIFOS-1:0] eligible,
   input  logic [1:0]           rr_ptr,
   output logic [1:0]           sel,
   output logic                 any
);
   logic [1:0] idx;

   // Scan from the farthest offset down so the closest eligible source wins last.
   always_comb begin
      sel = rr_ptr;
      any = 1'b0;
      idx = rr_ptr;
      for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
         idx = rr_ptr + 2'(k);
         if (eligible[idx]) begin
            sel = idx;
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/arbitro_rr_4a1.sv
// 4:1 round-robin arbiter draining four input FIFOs into one downstream FIFO,
// with per-grant bursts, almost-full stall and a wrapping count of forwarded words.
module arbitro_rr_4a1
   import arbitro_rr_4a1_pkg::*;
#(
   parameter int WORD_SIZE = 12,
   parameter int BURST     = 4
)(
   input logic              clk,
   input logic              reset,
   arbitro_rr_4a1_if.slave  bus
);
   // state | meaning
   // IDLE  | no input FIFO holds data
   // SERVE | popping the granted FIFO
   // STALL | data waiting but downstream almost full; grant/burst/rr_ptr frozen

   localparam logic [3:0] BURST_C = 4'(BURST);

   state_t                state, state_nx;
   logic [1:0]            grant, rr_ptr, scan_ptr, sel, sel_scan;
   logic [3:0]            burst_cnt, burst_nx;
   logic [NUM_FIFOS-1:0]  eligible;
   logic                  any_scan, keep, take;
   logic                  push_r;
   logic [WORD_SIZE-1:0]  data_r;
   logic [CUENTA_W-1:0]   cuenta_r;

   assign eligible = ~bus.fifos_empty;
   assign keep     = eligible[grant] && (burst_cnt < BURST_C);
   // A drained grant scans from grant+1 this very cycle, so no bubble waits on rr_ptr.
   assign scan_ptr = eligible[grant] ? rr_ptr : grant + 2'd1;

   arbitro_rr_4a1_sel u_sel (
      .eligible (eligible),
      .rr_ptr   (scan_ptr),
      .sel      (sel_scan),
      .any      (any_scan)
   );

   assign sel      = keep ? grant : sel_scan;
   assign take     = any_scan && !bus.fifo_almost_full;
   assign burst_nx = keep ? burst_cnt + 4'd1 : 4'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (any_scan) state_nx = bus.fifo_almost_full ? STALL : SERVE;
         end
         SERVE, STALL: begin
            if (!any_scan)                 state_nx = IDLE;
            else if (bus.fifo_almost_full) state_nx = STALL;
            else                           state_nx = SERVE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant     <= 2'd0;
         rr_ptr    <= 2'd0;
         burst_cnt <= 4'd0;
         push_r    <= 1'b0;
         data_r    <= '0;
      end else begin
         push_r <= take;
         if (take) begin
            grant     <= sel;
            burst_cnt <= burst_nx;
            data_r    <= bus.data_in[int'(sel)*WORD_SIZE +: WORD_SIZE];
         end
         if (take && burst_nx == BURST_C) begin
            rr_ptr <= sel + 2'd1;
         end else if (!eligible[grant]) begin
            rr_ptr <= grant + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cuenta_r <= '0;
      end else if (push_r) begin
         cuenta_r <= cuenta_r + 1'b1;
      end
   end

   assign bus.pop      = (take && !reset) ? onehot4(sel) : '0;
   assign bus.push     = push_r;
   assign bus.data_out = data_r;
   assign bus.grant    = grant;
   assign bus.idle     = (state == IDLE) && !push_r;
   assign bus.cuenta   = cuenta_r;
endmodule

// File: tb/tb_arbitro_rr_4a1.sv
// Directed bench for arbitro_rr_4a1: queue-modelled input FIFOs, per-cycle pop log
// and pushed-word log compared against hand-written expectations.
module tb_arbitro_rr_4a1;
   import arbitro_rr_4a1_pkg::*;

   localparam int W = 12;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   arbitro_rr_4a1_if #(.WORD_SIZE(W)) bus ();

   arbitro_rr_4a1 #(.WORD_SIZE(W), .BURST(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] fq [4][$];
   logic [3:0]   pop_log[$];
   logic [1:0]   grant_log[$];
   logic [W-1:0] push_log[$];
   logic [3:0]   exp_pop[$];
   logic [W-1:0] exp_word[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 4; i++) begin
         bus.fifos_empty[i] = (fq[i].size() == 0);
         bus.data_in[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : '0;
      end
   endtask

   task automatic load(input int f, input int n, input int first);
      for (int k = 0; k < n; k++) fq[f].push_back(W'(f*256 + first + k));
   endtask

   // One clock: sample at the falling edge, retire popped heads just after the rising edge.
   task automatic cycle(input logic af);
      logic [3:0] p;
      bus.fifo_almost_full = af;
      @(negedge clk);
      p = bus.pop;
      pop_log.push_back(p);
      grant_log.push_back(bus.grant);
      if (bus.push) push_log.push_back(bus.data_out);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (p[i] && fq[i].size() != 0) void'(fq[i].pop_front());
      end
      drive_inputs();
   endtask

   task automatic do_reset();
      for (int i = 0; i < 4; i++) fq[i].delete();
      pop_log.delete();
      grant_log.delete();
      push_log.delete();
      exp_pop.delete();
      exp_word.delete();
      bus.fifo_almost_full = 1'b0;
      drive_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic compare_logs(input string tag);
      for (int i = 0; i < pop_log.size(); i++)
         chk({tag, " pop"}, 32'(pop_log[i]), (i < exp_pop.size()) ? 32'(exp_pop[i]) : 32'd0);
      chk({tag, " push_count"}, 32'(push_log.size()), 32'(exp_word.size()));
      for (int i = 0; i < exp_word.size(); i++)
         chk({tag, " word"}, (i < push_log.size()) ? 32'(push_log[i]) : 32'hDEAD_BEEF,
             32'(exp_word[i]));
   endtask

   initial begin
      reset = 1'b1;
      bus.fifo_almost_full = 1'b0;
      bus.fifos_empty = 4'hF;
      bus.data_in = '0;

      // Reset asserted mid-burst while a push is in flight
      do_reset();
      chk("rst idle", 32'(bus.idle), 32'd1);
      chk("rst cuenta", 32'(bus.cuenta), 32'd0);
      for (int i = 0; i < 4; i++) load(i, 6, 1);
      drive_inputs();
      repeat (3) cycle(1'b0);
      chk("pre push", 32'(bus.push), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst pop", 32'(bus.pop), 32'd0);
      chk("midrst push", 32'(bus.push), 32'd0);
      chk("midrst cuenta", 32'(bus.cuenta), 32'd0);
      chk("midrst data_out", 32'(bus.data_out), 32'd0);
      chk("midrst idle", 32'(bus.idle), 32'd1);
      chk("midrst grant", 32'(bus.grant), 32'd0);
      @(negedge clk);
      chk("inrst pop", 32'(bus.pop), 32'd0);

      // Only FIFO2 holds three words
      do_reset();
      load(2, 3, 1);
      drive_inputs();
      exp_pop = '{4'b0100, 4'b0100, 4'b0100};
      exp_word = '{12'h201, 12'h202, 12'h203};
      repeat (6) cycle(1'b0);
      compare_logs("fifo2");
      chk("fifo2 cuenta", 32'(bus.cuenta), 32'd3);
      chk("fifo2 idle", 32'(bus.idle), 32'd1);

      // All four FIFOs with six words: four-word bursts then two-word tails
      do_reset();
      for (int i = 0; i < 4; i++) load(i, 6, 1);
      drive_inputs();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            exp_pop.push_back(4'(1 << i));
            exp_word.push_back(W'(i*256 + 1 + k));
         end
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 2; k++) begin
            exp_pop.push_back(4'(1 << i));
            exp_word.push_back(W'(i*256 + 5 + k));
         end
      repeat (28) cycle(1'b0);
      compare_logs("all4");
      chk("all4 cuenta", 32'(bus.cuenta), 32'd24);
      chk("all4 idle", 32'(bus.idle), 32'd1);

      // FIFO1 stalled for three cycles after its second pop
      do_reset();
      load(1, 5, 1);
      load(2, 2, 1);
      drive_inputs();
      exp_pop = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010,
                  4'b0100, 4'b0100, 4'b0010};
      exp_word = '{12'h101, 12'h102, 12'h103, 12'h104, 12'h201, 12'h202, 12'h105};
      cycle(1'b0);
      cycle(1'b0);
      repeat (3) cycle(1'b1);
      repeat (9) cycle(1'b0);
      compare_logs("stall");
      for (int i = 2; i < 5; i++) chk("stall grant", 32'(grant_log[i]), 32'd1);
      chk("stall cuenta", 32'(bus.cuenta), 32'd7);

      // 33 words through FIFO0 wraps the counter to 1
      do_reset();
      load(0, 33, 1);
      drive_inputs();
      for (int k = 0; k < 33; k++) begin
         exp_pop.push_back(4'b0001);
         exp_word.push_back(W'(1 + k));
      end
      repeat (36) cycle(1'b0);
      compare_logs("wrap");
      chk("wrap cuenta", 32'(bus.cuenta), 32'd1);

      // FIFO3 granted and drained by one word while FIFO0 and FIFO1 fill
      do_reset();
      load(3, 1, 1);
      drive_inputs();
      cycle(1'b0);
      load(0, 2, 1);
      load(1, 1, 1);
      drive_inputs();
      cycle(1'b0);
      chk("wrap3 rr_ptr", 32'(dut.rr_ptr), 32'd0);
      repeat (4) cycle(1'b0);
      exp_pop = '{4'b1000, 4'b0001, 4'b0001, 4'b0010};
      exp_word = '{12'h301, 12'h001, 12'h002, 12'h101};
      compare_logs("wrap3");
      chk("wrap3 cuenta", 32'(bus.cuenta), 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
